// File: rtl/imem_wait_responder.sv
// Instruction-memory responder for the fetch stage. Answers the fetch
// address with a 32-bit word after LAT wait states and raises ready_F,
// which the pipeline uses as the PC enable. Includes a preload write port.
module imem_wait_responder #(
    parameter int size = 64,
    parameter int N    = 6,
    parameter int LAT  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] imem_addr_F,
    input  logic            wr_en,
    input  logic [size-1:0] wr_addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     instr_F,
    output logic            ready_F,
    output logic            fault_F
);

    localparam int DEPTH = 1 << N;
    localparam int CW    = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(LAT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [size-1:0] r_a_q;
    logic [size-1:0] w_a_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            w_load;

    logic [31:0]     r_mem [0:DEPTH-1];
    logic [31:0]     r_instr;
    logic            r_fault;

    logic            w_wr_ok;
    logic [N-1:0]    w_resp_idx;
    logic            w_resp_fault;
    logic [31:0]     w_resp_data;
    logic            w_same;
    logic            w_unused;

    // Byte-lane bits of the preload address are don't-care.
    assign w_unused = ^wr_addr[1:0];

    assign w_wr_ok    = wr_en && (wr_addr[size-1:N+2] == '0);
    assign w_same     = (imem_addr_F == r_a_q);

    // A response is always registered for the address present at the edge,
    // so it is looked up directly from imem_addr_F (equal to the next a_q).
    assign w_resp_idx   = imem_addr_F[N+1:2];
    assign w_resp_fault = (imem_addr_F[1:0] != 2'b00) || (imem_addr_F[size-1:N+2] != '0);
    assign w_resp_data  = (w_wr_ok && (wr_addr[N+1:2] == w_resp_idx)) ? wr_data
                                                                       : r_mem[w_resp_idx];

    // Preload write port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr[N+1:2]] <= wr_data;
        end
    end

    // FSM state, latched address and wait-state counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a_q   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_a_q   <= w_a_next;
            r_count <= w_count_next;
        end
    end

    // Next-state logic: latch/redirect, count down, and response load strobe.
    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a_q;
        w_count_next = r_count;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                w_a_next = imem_addr_F;
                if (LAT == 0) begin
                    w_state_next = DONE;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = BUSY;
                    w_count_next = LAT_C;
                end
            end
            BUSY: begin
                if (!w_same) begin
                    // Redirect takes priority over a count that is about to expire.
                    w_a_next = imem_addr_F;
                    if (LAT == 0) begin
                        w_state_next = DONE;
                        w_load       = 1'b1;
                    end else begin
                        w_count_next = LAT_C;
                    end
                end else if (r_count <= ONE_C) begin
                    w_state_next = DONE;
                    w_load       = 1'b1;
                end else begin
                    w_count_next = r_count - ONE_C;
                end
            end
            DONE: begin
                if (!w_same) begin
                    w_a_next = imem_addr_F;
                    if (LAT == 0) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = BUSY;
                        w_count_next = LAT_C;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Response register; also tracks preload writes to the word being served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= '0;
            r_fault <= 1'b0;
        end else if (w_load) begin
            r_instr <= w_resp_fault ? '0 : w_resp_data;
            r_fault <= w_resp_fault;
        end else if ((r_state == DONE) && (w_state_next == DONE) && !r_fault &&
                     w_wr_ok && (wr_addr[N+1:2] == r_a_q[N+1:2])) begin
            r_instr <= wr_data;
        end
    end

    assign instr_F = r_instr;
    assign ready_F = (r_state == DONE) && w_same;
    assign fault_F = ready_F && r_fault;

endmodule
